// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that sums CHUNK bits per clock.
// Operands are captured on the input handshake. Each RUN cycle then adds one
// chunk and keeps the inter-chunk carry in a register, which keeps the carry
// chain CHUNK bits long. The finished result is published on the output
// registers and held there until the next operation completes.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Operands as captured at accept time. b is stored already inverted for
    // subtraction, so the datapath only ever adds.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] work_reg;

    // Combinational view of the chunk being processed this cycle.
    int               base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] work_next;
    logic             ovf_next;

    // State register; reset is sampled on the clock edge.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values and the update order inside the block does not matter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One chunk of the sum, plus the working value with that chunk merged in.
    // The overflow term is taken from the merged value, so on the last chunk
    // it sees the final MSB.
    always_comb begin
        base      = int'(idx) * CHUNK;
        a_chunk   = a_reg[base +: CHUNK];
        b_chunk   = b_reg[base +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
        work_next = work_reg;
        work_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        ovf_next  = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (work_next[WIDTH-1] != a_reg[WIDTH-1]);
    end

    // Datapath: capture on accept, accumulate during RUN, and publish the
    // result only on the last chunk so partial sums never reach the outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            carry_reg    <= 1'b0;
            idx          <= '0;
            work_reg     <= '0;
            out_sum      <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : carry;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    work_reg  <= work_next;
                    carry_reg <= chunk_sum[CHUNK];
                    idx       <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        out_sum      <= work_next;
                        out_carry    <= chunk_sum[CHUNK];
                        out_overflow <= ovf_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor, the sequential successor to the combinational half/full/16-bit adders in the arithmetic library. It adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register. This trades latency for a narrow carry chain. It sits behind a valid/ready handshake on both sides, so it can be dropped between pipeline stages of the ALU datapath.

## Interface
Parameters:
- WIDTH, 16, operand and result width.
- CHUNK, 4, bits summed per cycle. Must divide WIDTH exactly, with 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry  input  1  carry-in. Ignored when sub=1.
- sub  input  1  0: a+b+carry; 1: a-b (computed as a + ~b + 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  WIDTH  result.
- out_carry  output  1  carry out of the MSB. In sub mode, 1 means no borrow.
- out_overflow  output  1  two's-complement signed overflow.

## Operation
- State machine has three states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid at a rising edge:
    - latch a;
    - latch b_eff = sub ? ~b : b;
    - set carry register = sub ? 1 : carry;
    - set chunk index to 0 and go to RUN.
- **RUN**
  - in_ready=0, out_valid=0.
  - Each cycle, form {c, s} = a[idx] + b_eff[idx] + carry reg, where [idx] is bits idx*CHUNK .. idx*CHUNK+CHUNK-1.
  - Write s into the working register at chunk idx, store c, and increment idx.
  - On the cycle idx=N-1, do all of the following, then go to DONE:
    - copy the completed working value to out_sum;
    - set out_carry = final c;
    - set out_overflow = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
- **DONE**
  - out_valid=1, in_ready=0.
  - On out_ready at a rising edge, go to IDLE. A new operand cannot be accepted in that same edge.
- Result holding:
  - out_sum, out_carry and out_overflow change only on the transition into DONE.
  - They hold the last completed result while in IDLE and RUN. Partial sums are never visible on them.
- Width rule: all arithmetic is modulo 2^WIDTH. The carry out is reported only through out_carry.
- Inputs are sampled only at the accepting edge. Later changes to a, b, carry or sub have no effect.
- in_valid in RUN or DONE is ignored; there is no queueing.
- CHUNK=WIDTH: RUN lasts exactly one cycle. CHUNK=1: bit-serial operation, RUN lasts WIDTH cycles.

## Timing
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, in_ready=1 from the following cycle;
  - out_valid=0, out_sum=0, out_carry=0, out_overflow=0;
  - carry register, index and working register cleared.
- Reset asserted mid-RUN or in DONE aborts the operation. No result is produced and the outputs return to their reset values.
- Latency: operands accepted at edge k; out_valid=1 from edge k+N.
- Throughput: with out_ready held high, one result per N+2 cycles.
- Backpressure: out_valid, out_sum, out_carry and out_overflow stay stable while out_ready=0, for an unbounded time.
- Handshake edges: in_valid && in_ready and out_valid && out_ready are the only transfer events. Both are sampled at the rising edge.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.

1. a=0x1234, b=0x4321, carry=0, sub=0 → out_sum=0x5555, out_carry=0, out_overflow=0; out_valid rises exactly 4 cycles after accept.
2. a=0xFFFF, b=0x0000, carry=1 (carry ripples through all chunks) → out_sum=0x0000, out_carry=1, out_overflow=0. Then a=0x7FFF, b=0x0001, carry=0 → 0x8000, out_carry=0, out_overflow=1.
3. Subtraction:
   - sub=1, a=0x0005, b=0x0007, carry=1 (ignored) → 0xFFFE, out_carry=0, out_overflow=0.
   - a=0x8000, b=0x0001 → 0x7FFF, out_carry=1, out_overflow=1.
4. Backpressure: hold out_ready=0 for 6 cycles after out_valid. Toggle in_valid and operands during this time → outputs unchanged, in_ready=0. Release out_ready → IDLE, and the next accept works.
5. Reset: reset_n=0 for one cycle during the 2nd RUN cycle → out_valid never asserts for that op; all outputs 0; in_ready=1 the next cycle.
6. Parameter sweep: CHUNK=1 and CHUNK=16 with 1000 random (a, b, carry, sub) each. Compare against a+b+carry and a-b → bit-exact sum, carry and overflow; latency 16 and 1 cycles respectively.
